// File: rtl/button_decoder.sv
// rtl/button_decoder.sv - push-button synchroniser, debouncer and short/long/double press classifier
module button_decoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int GAP_CYCLES      = 15000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       boton,
    output logic       btn_db,
    output logic       press_valid,
    output logic [1:0] press_code,
    output logic       busy
);

    localparam int MAX_DL = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int MAX_P  = (MAX_DL > GAP_CYCLES) ? MAX_DL : GAP_CYCLES;
    localparam int CW     = $clog2(MAX_P);

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    localparam logic [1:0] CODE_NONE   = 2'b00;
    localparam logic [1:0] CODE_SHORT  = 2'b01;
    localparam logic [1:0] CODE_LONG   = 2'b10;
    localparam logic [1:0] CODE_DOUBLE = 2'b11;

    typedef enum logic [1:0] {IDLE, PRESSED, WAIT_GAP, WAIT_RELEASE} state_t;

    logic          r_sync1, r_sync2;
    logic [CW-1:0] r_db_cnt;
    logic          r_btn_db, r_db_d;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_dur, w_dur_nxt;
    logic          r_valid, w_valid_nxt;
    logic [1:0]    r_code, w_code_nxt;
    logic          w_rise, w_fall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db_cnt <= '0;
            r_btn_db <= 1'b0;
            r_db_d   <= 1'b0;
        end else begin
            r_sync1 <= boton;
            r_sync2 <= r_sync1;
            r_db_d  <= r_btn_db;
            // Any return to the current level restarts the stability window.
            if (r_sync2 == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_btn_db <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_rise = r_btn_db & ~r_db_d;
    assign w_fall = ~r_btn_db & r_db_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_dur   <= '0;
            r_valid <= 1'b0;
            r_code  <= CODE_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_dur   <= w_dur_nxt;
            r_valid <= w_valid_nxt;
            r_code  <= w_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dur_nxt   = r_dur;
        w_valid_nxt = 1'b0;
        w_code_nxt  = CODE_NONE;
        case (r_state)
            IDLE: begin
                w_dur_nxt = '0;
                if (w_rise) w_state_nxt = PRESSED;
            end
            PRESSED: begin
                // A release on the same cycle as the long threshold counts as short.
                if (w_fall) begin
                    w_state_nxt = WAIT_GAP;
                    w_dur_nxt   = '0;
                end else if (r_dur == LONG_LAST) begin
                    w_state_nxt = WAIT_RELEASE;
                    w_dur_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_code_nxt  = CODE_LONG;
                end else begin
                    w_dur_nxt = r_dur + 1'b1;
                end
            end
            WAIT_GAP: begin
                if (w_rise) begin
                    w_state_nxt = WAIT_RELEASE;
                    w_dur_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_code_nxt  = CODE_DOUBLE;
                end else if (r_dur == GAP_LAST) begin
                    w_state_nxt = IDLE;
                    w_dur_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_code_nxt  = CODE_SHORT;
                end else begin
                    w_dur_nxt = r_dur + 1'b1;
                end
            end
            WAIT_RELEASE: begin
                w_dur_nxt = '0;
                if (w_fall) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_dur_nxt   = '0;
            end
        endcase
    end

    assign btn_db      = r_btn_db;
    assign press_valid = r_valid;
    assign press_code  = r_code;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_button_decoder.sv
// tb/tb_button_decoder.sv - scoreboard bench for button_decoder with directed gestures
module tb_button_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       boton = 1'b0;
    logic       btn_db;
    logic       press_valid;
    logic [1:0] press_code;
    logic       busy;

    button_decoder #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (40),
        .GAP_CYCLES     (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .boton      (boton),
        .btn_db     (btn_db),
        .press_valid(press_valid),
        .press_code (press_code),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] code;
        int         at;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_event(input logic [1:0] code, input int at, input logic b);
        exp_t e;
        e.code = code;
        e.at   = at;
        e.busy = b;
        sb.push_back(e);
    endtask

    // Monitor: every strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst) begin
            if (press_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got code %0d at cycle %0d expected none", press_code, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("event_code", int'(press_code), int'(mon_e.code));
                    check("event_cycle", cyc, mon_e.at);
                    check("event_busy", int'(busy), int'(mon_e.busy));
                end
            end else begin
                check("code_when_idle", int'(press_code), 0);
            end
        end
    end

    initial begin
        // Reset held with the button pressed.
        rst   = 1'b0;
        boton = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("reset_btn_db", int'(btn_db), 0);
            check("reset_valid", int'(press_valid), 0);
            check("reset_code", int'(press_code), 0);
            check("reset_busy", int'(busy), 0);
        end
        boton = 1'b0;
        rst   = 1'b1;
        tick(10);

        // Bounce: 2-cycle toggles for 20 cycles, then a clean press of 15 cycles.
        for (int i = 0; i < 5; i++) begin
            boton = 1'b1;
            tick();
            check("bounce_db", int'(btn_db), 0);
            tick();
            check("bounce_db", int'(btn_db), 0);
            boton = 1'b0;
            tick();
            check("bounce_db", int'(btn_db), 0);
            tick();
            check("bounce_db", int'(btn_db), 0);
        end
        boton = 1'b1;
        tick(5);
        check("bounce_before_rise", int'(btn_db), 0);
        tick();
        check("bounce_rise", int'(btn_db), 1);
        tick(9);
        boton = 1'b0;
        expect_event(2'b01, cyc + 27, 1'b0);
        tick(40);

        // Long press held 100 cycles.
        boton = 1'b1;
        expect_event(2'b10, cyc + 47, 1'b1);
        tick(100);
        boton = 1'b0;
        tick(60);

        // Double press: 10 high, 8 low, 10 high.
        boton = 1'b1;
        tick(10);
        boton = 1'b0;
        tick(8);
        boton = 1'b1;
        expect_event(2'b11, cyc + 7, 1'b1);
        tick(10);
        boton = 1'b0;
        tick(40);

        // Second rise lands on the last gap cycle: still a double.
        boton = 1'b1;
        tick(10);
        boton = 1'b0;
        tick(20);
        boton = 1'b1;
        expect_event(2'b11, cyc + 7, 1'b1);
        tick(10);
        boton = 1'b0;
        tick(40);

        // One cycle later: gap expires first, then the re-press is a new short.
        boton = 1'b1;
        tick(10);
        boton = 1'b0;
        expect_event(2'b01, cyc + 27, 1'b0);
        tick(21);
        boton = 1'b1;
        tick(10);
        boton = 1'b0;
        expect_event(2'b01, cyc + 27, 1'b0);
        tick(60);

        // Reset in the middle of a press discards the gesture.
        boton = 1'b1;
        tick(12);
        check("midrst_busy_before", int'(busy), 1);
        rst   = 1'b0;
        boton = 1'b0;
        tick();
        check("midrst_busy_after", int'(busy), 0);
        check("midrst_btn_db", int'(btn_db), 0);
        rst = 1'b1;
        tick(80);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_decoder.md
Name: button_decoder

Overview:
- Input-side user-interface block for the Tamagotchi design. It synchronises and debounces the raw push-button (`boton`) and classifies each gesture as short, long or double press.
- It delivers one single-cycle coded event to the state FSM, in place of the raw button level.
- It is the input counterpart of the display path: it turns user actions into commands, where the display turns state values into seven-segment output.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles the synchronised input must stay stable before the debounced level changes (10 ms at 50 MHz).
- LONG_CYCLES, 50000000: debounced-high cycles that make a long press (1 s).
- GAP_CYCLES, 15000000: maximum debounced-low cycles between release and re-press for a double press (300 ms).
- Constraint: every parameter is at least 2. Counter widths are $clog2 of the largest parameter.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-low.
- boton, input, 1: raw, asynchronous, bouncing button.
- btn_db, output, 1: debounced button level.
- press_valid, output, 1: one-cycle strobe, event present.
- press_code, output, 2: 01 short, 10 long, 11 double, 00 none. Held at 00 when press_valid is 0.
- busy, output, 1: high whenever the classifier is not in IDLE.

Behaviour:
- Reset (rst=0 sampled on a clk edge):
  - Synchroniser flops, btn_db, all counters, press_valid and press_code go to 0.
  - busy goes to 0 and the FSM goes to IDLE.
  - Reset mid-gesture discards the gesture; no event is emitted.
- Synchroniser: two flops on boton, giving `sync`.
- Debouncer:
  - Stable counter clears whenever sync == btn_db.
  - Otherwise it increments each cycle.
  - When it reaches DEBOUNCE_CYCLES-1, btn_db <= sync on that edge and the counter clears.
  - Any sync glitch shorter than DEBOUNCE_CYCLES clears the counter and leaves btn_db unchanged.
  - Latency from a clean boton edge to a btn_db edge is 2 + DEBOUNCE_CYCLES cycles.
- Edge detect: `rise`/`fall` come from btn_db versus its one-cycle-delayed copy.
- Classifier FSM (states IDLE, PRESSED, WAIT_GAP, WAIT_RELEASE; one duration counter `dur`):
  - IDLE: on rise go to PRESSED, dur <= 0.
  - PRESSED:
    - dur increments each cycle.
    - If fall occurs first: go to WAIT_GAP, dur <= 0.
    - If dur == LONG_CYCLES-1 while still high: emit LONG immediately (not on release) and go to WAIT_RELEASE.
  - WAIT_GAP:
    - dur increments each cycle.
    - On rise: emit DOUBLE and go to WAIT_RELEASE.
    - If dur == GAP_CYCLES-1 with no rise: emit SHORT and go to IDLE.
    - Rise and gap expiry on the same cycle: rise wins, DOUBLE only.
  - WAIT_RELEASE: wait for fall, then go to IDLE. No further events; holding after LONG or DOUBLE never repeats.
- Emission:
  - press_valid and press_code are registered. They assert for exactly one cycle, on the edge after the deciding condition.
  - At most one event per gesture; the next gesture is not seen until IDLE.
- Timing consequences:
  - A short press is reported GAP_CYCLES after release, which is the inherent cost of double-press detection.
  - A long press is reported LONG_CYCLES after the debounced rise.
- Button held through reset release: after debounce, btn_db rises and it is treated as a new press.
- Saturation: dur never needs to exceed its compare value and does not wrap; every exit resets it.

Test Plan:
(All runs use DEBOUNCE_CYCLES=4, LONG_CYCLES=40, GAP_CYCLES=20, with boton changes aligned to clk.)
- Reset: hold rst=0 with boton=1 for 10 cycles -> btn_db=0, press_valid=0, press_code=00, busy=0 throughout.
- Bounce filter: toggle boton 1/0 every 2 cycles for 20 cycles, then hold 1 -> btn_db stays 0 during toggling and rises exactly 6 cycles after the final stable edge.
- Short press: hold boton high 15 cycles, then low -> one press_valid pulse with press_code=01, 20 cycles after btn_db falls; busy returns to 0 the same cycle.
- Long press: hold boton high 100 cycles -> one pulse with code=10, 40 cycles after btn_db rises (+1 register cycle), with no second event on release.
- Double press: press 10 cycles, release 8, press 10 -> exactly one pulse with code=11, one cycle after the second btn_db rise; no 01 event.
- Gap boundary and mid-reset:
  - Second rise landing on gap cycle 19 -> code=11.
  - Separately, assert rst=0 during PRESSED -> no event, FSM in IDLE, busy=0 next cycle.
